// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller and its bit sampler.
// Used by uart_rx_ctrl (optional error counters under UART_RX_CTRL_ERR_CNT_EN) and uart_rx_sampler.
package uart_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int MIN_PRESCALE = 4;

    // Three votes are taken around mid-bit: one before, at, and after P/2.
    localparam int NUM_TAPS        = 3;
    localparam int SAMPLE_OFS_PRE  = -1;
    localparam int SAMPLE_OFS_MID  = 0;
    localparam int SAMPLE_OFS_POST = 1;

    function automatic int sample_ofs(input int tap);
        case (tap)
            0:       return SAMPLE_OFS_PRE;
            1:       return SAMPLE_OFS_MID;
            default: return SAMPLE_OFS_POST;
        endcase
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Majority-of-three mid-bit sampler: votes at P/2-1, P/2, P/2+1, resolved on the last tap
// and held for the rest of the bit.
module uart_rx_sampler
    import uart_rx_ctrl_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      rx_in,
    output logic                      sampled_bit
);

    logic [PRESCALE_WIDTH-1:0] half_p;
    logic [NUM_TAPS-1:0]       tap_hit;
    logic [1:0]                vote_q, vote_d;
    logic                      bit_q, bit_d;
    logic                      vote_now;

    assign half_p = prescale >> 1;

    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
        assign tap_hit[gi] = (int'(edge_cnt) == int'(half_p) + sample_ofs(gi));
    end

    assign vote_now = majority3(vote_q[0], vote_q[1], rx_in);

    always_comb begin
        vote_d = vote_q;
        bit_d  = bit_q;
        if (tap_hit[0]) vote_d[0] = rx_in;
        if (tap_hit[1]) vote_d[1] = rx_in;
        if (tap_hit[2]) bit_d = vote_now;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            vote_q <= 2'b11;
            bit_q  <= 1'b1;
        end else begin
            vote_q <= vote_d;
            bit_q  <= bit_d;
        end
    end

    // The resolving tap can coincide with the last edge of the bit (P=4), so bypass the hold flop.
    assign sampled_bit = tap_hit[2] ? vote_now : bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start qualification, LSB-first deserialisation, optional parity
// and stop check. Define UART_RX_CTRL_ERR_CNT_EN to add saturating parity/stop error counters.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
`ifdef UART_RX_CTRL_ERR_CNT_EN
    ,
    output logic [7:0]                par_err_cnt,
    output logic [7:0]                stp_err_cnt
`endif
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e                 state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      par_bad_q, par_bad_d;

    logic sampled_bit;
    logic last_edge;
    logic prescale_ok;

    uart_rx_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .clk        (CLK),
        .srst       (RST),
        .edge_cnt   (edge_cnt_q),
        .prescale   (prescale_q),
        .rx_in      (RX_IN),
        .sampled_bit(sampled_bit)
    );

    assign last_edge   = (edge_cnt_q == prescale_q - PRESCALE_WIDTH'(1));
    assign prescale_ok = (Prescale >= PRESCALE_WIDTH'(MIN_PRESCALE)) && !Prescale[0];

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = last_edge ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_bad_d  = par_bad_q;
        data_valid = 1'b0;
        par_err    = 1'b0;
        stp_err    = 1'b0;

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                // The detect cycle is edge 0, so the start bit continues from edge 1.
                if (!RX_IN && prescale_ok) begin
                    state_d    = START;
                    edge_cnt_d = PRESCALE_WIDTH'(1);
                    bit_cnt_d  = '0;
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_bad_d  = 1'b0;
                end
            end
            START: begin
                if (last_edge) state_d = sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (last_edge) begin
                    shift_d[bit_cnt_q] = sampled_bit;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    par_bad_d = sampled_bit ^ (^shift_q) ^ par_typ_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    state_d = IDLE;
                    stp_err = !sampled_bit;
                    par_err = par_bad_q;
                    if (sampled_bit && !par_bad_q) begin
                        data_valid = 1'b1;
                        p_data_d   = shift_q;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_bad_q  <= par_bad_d;
        end
    end

    // The new word is visible in the same cycle as its data_valid pulse, then held.
    assign P_DATA = data_valid ? shift_q : p_data_q;

`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0] par_err_cnt_q, par_err_cnt_d;
    logic [7:0] stp_err_cnt_q, stp_err_cnt_d;

    always_comb begin
        par_err_cnt_d = par_err_cnt_q;
        stp_err_cnt_d = stp_err_cnt_q;
        if (par_err && par_err_cnt_q != 8'hFF) par_err_cnt_d = par_err_cnt_q + 8'd1;
        if (stp_err && stp_err_cnt_q != 8'hFF) stp_err_cnt_d = stp_err_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            par_err_cnt_q <= '0;
            stp_err_cnt_q <= '0;
        end else begin
            par_err_cnt_q <= par_err_cnt_d;
            stp_err_cnt_q <= stp_err_cnt_d;
        end
    end

    assign par_err_cnt = par_err_cnt_q;
    assign stp_err_cnt = stp_err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: the driver queues hand-computed outcomes per frame,
// a monitor pops one entry for every pulse the DUT emits.
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = PW'(8);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          dv;
        bit          pe;
        bit          se;
        logic [7:0]  data;
        int          at_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t drv_e;

    uart_rx_ctrl #(
        .DATA_WIDTH    (DW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .Prescale  (Prescale),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_bit(input bit v, input int p, input bit spike);
        for (int k = 0; k < p; k++) begin
            RX_IN = (spike && k == p / 2) ? ~v : v;
            @(posedge CLK);
            #1;
        end
    endtask

    // Called just after a rising edge; the start bit occupies the detect cycle onwards.
    task automatic send_frame(input logic [7:0] data, input int p, input bit pen, input bit ptyp,
                              input bit par_bit, input bit stop_bit, input bit spike,
                              input bit exp_dv, input bit exp_pe, input bit exp_se,
                              input logic [7:0] exp_data);
        int nbits;
        nbits          = 2 + DW + (pen ? 1 : 0);
        Prescale       = PW'(p);
        PAR_EN         = pen;
        PAR_TYP        = ptyp;
        drv_e.dv       = exp_dv;
        drv_e.pe       = exp_pe;
        drv_e.se       = exp_se;
        drv_e.data     = exp_data;
        drv_e.at_cyc   = cyc + nbits * p - 1;
        exp_q.push_back(drv_e);
        $display("send data=0x%02h P=%0d par_en=%0d par_typ=%0d par=%0d stop=%0d spike=%0d at cycle %0d",
                 data, p, pen, ptyp, par_bit, stop_bit, spike, cyc);
        drive_bit(1'b0, p, 1'b0);
        for (int i = 0; i < DW; i++) drive_bit(data[i], p, spike);
        if (pen) drive_bit(par_bit, p, 1'b0);
        drive_bit(stop_bit, p, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && (data_valid || par_err || stp_err)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'({data_valid, par_err, stp_err}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("flags_dv_pe_se", int'({data_valid, par_err, stp_err}),
                          int'({mon_e.dv, mon_e.pe, mon_e.se}));
                    check("p_data", int'(P_DATA), int'(mon_e.data));
                    check("pulse_cycle", cyc, mon_e.at_cyc);
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("reset_p_data", int'(P_DATA), 0);
        check("reset_pulses", int'({data_valid, par_err, stp_err}), 0);
        @(posedge CLK);
        #1;

        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
        idle(4);
        // 0x3C has four ones, so even parity expects 0; a 1 is sent.
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
        idle(4);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F);
        idle(4);

        $display("glitch: RX_IN low 4 cycles at P=16, cycle %0d", cyc);
        Prescale = PW'(16);
        for (int k = 0; k < 4; k++) drive_bit(1'b0, 1, 1'b0);
        idle(24);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        idle(4);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81);
        idle(4);

        $display("odd prescale 7: RX_IN low 20 cycles, cycle %0d", cyc);
        Prescale = PW'(7);
        for (int k = 0; k < 20; k++) drive_bit(1'b0, 1, 1'b0);
        idle(4);

        // Minimum prescale with odd parity: four ones in 0x3C needs parity bit 1.
        send_frame(8'h3C, 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
        idle(4);
        // 0x01 with even parity needs 1; send 0 and a bad stop bit together.
        send_frame(8'h01, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
        idle(12);

        $display("reset mid-frame of 0x77, cycle %0d", cyc);
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 8, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 8, 1'b0);
        RST   = 1'b1;
        RX_IN = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("midreset_p_data", int'(P_DATA), 0);
        check("midreset_pulses", int'({data_valid, par_err, stp_err}), 0);
        @(posedge CLK);
        #1;
        idle(10);
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
        idle(20);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
